// File: rtl/video_timing.sv
// Free-running raster timing generator: signed screen coordinates, syncs, active-video
// enable and line/frame strobes, all registered from the next-state counter values.
module video_timing #(
  parameter int COORDSPC = 16,
  parameter int H_RES    = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_RES    = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic                       video_clk_pix,
  input  logic                       video_rst,
  output logic signed [COORDSPC-1:0] sx,
  output logic signed [COORDSPC-1:0] sy,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       video_enable,
  output logic                       line_start,
  output logic                       frame_start,
  output logic [15:0]                frame_count
);

  localparam int H_STA_I  = -(H_FP + H_SYNC + H_BP);
  localparam int H_END_I  = H_RES - 1;
  localparam int V_STA_I  = -(V_FP + V_SYNC + V_BP);
  localparam int V_END_I  = V_RES - 1;
  localparam int HS_STA_I = H_STA_I + H_FP;
  localparam int HS_END_I = HS_STA_I + H_SYNC - 1;
  localparam int VS_STA_I = V_STA_I + V_FP;
  localparam int VS_END_I = VS_STA_I + V_SYNC - 1;

  localparam longint C_MIN = -(64'sd1 <<< (COORDSPC - 1));
  localparam longint C_MAX = (64'sd1 <<< (COORDSPC - 1)) - 64'sd1;

  // Refuse to elaborate a raster whose coordinates cannot be represented.
  generate
    if (longint'(H_STA_I) < C_MIN || longint'(H_END_I) > C_MAX) begin : g_h_range_err
      $error("video_timing: horizontal range does not fit in COORDSPC bits");
    end
    if (longint'(V_STA_I) < C_MIN || longint'(V_END_I) > C_MAX) begin : g_v_range_err
      $error("video_timing: vertical range does not fit in COORDSPC bits");
    end
  endgenerate

  localparam logic signed [COORDSPC-1:0] H_STA  = COORDSPC'(H_STA_I);
  localparam logic signed [COORDSPC-1:0] H_END  = COORDSPC'(H_END_I);
  localparam logic signed [COORDSPC-1:0] V_STA  = COORDSPC'(V_STA_I);
  localparam logic signed [COORDSPC-1:0] V_END  = COORDSPC'(V_END_I);
  localparam logic signed [COORDSPC-1:0] HS_STA = COORDSPC'(HS_STA_I);
  localparam logic signed [COORDSPC-1:0] HS_END = COORDSPC'(HS_END_I);
  localparam logic signed [COORDSPC-1:0] VS_STA = COORDSPC'(VS_STA_I);
  localparam logic signed [COORDSPC-1:0] VS_END = COORDSPC'(VS_END_I);
  localparam logic signed [COORDSPC-1:0] C_ONE  = COORDSPC'(1);

  logic signed [COORDSPC-1:0] sx_reg, sx_next;
  logic signed [COORDSPC-1:0] sy_reg, sy_next;
  logic                       hsync_reg, hsync_next;
  logic                       vsync_reg, vsync_next;
  logic                       video_enable_reg, video_enable_next;
  logic                       line_start_reg, line_start_next;
  logic                       frame_start_reg, frame_start_next;
  logic [15:0]                frame_count_reg, frame_count_next;

  // Counter advance; the reset state (H_END, V_END) rolls straight into a new frame.
  always_comb begin
    sx_next = sx_reg + C_ONE;
    sy_next = sy_reg;
    if (sx_reg == H_END) begin
      sx_next = H_STA;
      sy_next = (sy_reg == V_END) ? V_STA : sy_reg + C_ONE;
    end
  end

  // Decode from the next-state coordinates so every flag matches the sx/sy it ships with.
  always_comb begin
    hsync_next        = ((sx_next >= HS_STA) && (sx_next <= HS_END)) ? H_POL : !H_POL;
    vsync_next        = ((sy_next >= VS_STA) && (sy_next <= VS_END)) ? V_POL : !V_POL;
    video_enable_next = !sx_next[COORDSPC-1] && !sy_next[COORDSPC-1];
    line_start_next   = (sx_next == H_STA);
    frame_start_next  = (sx_next == H_STA) && (sy_next == V_STA);
    frame_count_next  = frame_start_next ? frame_count_reg + 16'd1 : frame_count_reg;
  end

  always_ff @(posedge video_clk_pix or posedge video_rst) begin
    if (video_rst) begin
      sx_reg           <= H_END;
      sy_reg           <= V_END;
      hsync_reg        <= !H_POL;
      vsync_reg        <= !V_POL;
      video_enable_reg <= 1'b0;
      line_start_reg   <= 1'b0;
      frame_start_reg  <= 1'b0;
      frame_count_reg  <= 16'hFFFF;
    end else begin
      sx_reg           <= sx_next;
      sy_reg           <= sy_next;
      hsync_reg        <= hsync_next;
      vsync_reg        <= vsync_next;
      video_enable_reg <= video_enable_next;
      line_start_reg   <= line_start_next;
      frame_start_reg  <= frame_start_next;
      frame_count_reg  <= frame_count_next;
    end
  end

  assign sx           = sx_reg;
  assign sy           = sy_reg;
  assign hsync        = hsync_reg;
  assign vsync        = vsync_reg;
  assign video_enable = video_enable_reg;
  assign line_start   = line_start_reg;
  assign frame_start  = frame_start_reg;
  assign frame_count  = frame_count_reg;

endmodule

// File: tb/tb_video_timing.sv
// Scoreboard bench for video_timing on a tiny 14x7 raster: stimulus pushes expected
// per-cycle outputs, a negedge monitor pops and compares them, plus cadence checks.
module tb_video_timing;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] sx, sy;
  logic               hsync, vsync, video_enable, line_start, frame_start;
  logic [15:0]        frame_count;

  video_timing #(
    .COORDSPC(16), .H_RES(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1)
  ) dut (
    .video_clk_pix(clk),
    .video_rst(rst),
    .sx(sx),
    .sy(sy),
    .hsync(hsync),
    .vsync(vsync),
    .video_enable(video_enable),
    .line_start(line_start),
    .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sx; int sy; bit hs; bit vs; bit en; bit ls; bit fs; int fc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: cycle index within a 98-cycle frame
  bit m_rst = 1'b1;
  int m_t   = 0;
  int m_fc  = 0;

  task automatic chk(input string name, input int act, input int req, input int cyc);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.sx = 7; e.sy = 3; e.hs = 1'b0; e.vs = 1'b0;
    e.en = 1'b0; e.ls = 1'b0; e.fs = 1'b0; e.fc = 16'hFFFF;
    return e;
  endfunction

  // Hand-derived raster: 14 columns from -6, 7 rows from -3, hsync at -4/-3, vsync at row -2
  function automatic exp_t run_exp(input int t, input int fc);
    exp_t e;
    int hx, vy;
    hx   = t % 14;
    vy   = t / 14;
    e.sx = hx - 6;
    e.sy = vy - 3;
    e.hs = (e.sx == -4) || (e.sx == -3);
    e.vs = (e.sy == -2);
    e.en = (e.sx >= 0) && (e.sy >= 0);
    e.ls = (hx == 0);
    e.fs = (t == 0);
    e.fc = fc;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      m_rst = 1'b1;
    end else if (m_rst) begin
      m_rst = 1'b0;
      m_t   = 0;
      m_fc  = 0;
    end else begin
      m_t = (m_t + 1) % 98;
      if (m_t == 0) m_fc = (m_fc + 1) & 16'hFFFF;
    end
    sb.push_back(m_rst ? reset_exp() : run_exp(m_t, m_fc));
  endtask

  // Assert reset asynchronously between edges; the following negedge must already see it
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst   = 1'b1;
    m_rst = 1'b1;
    sb.push_back(reset_exp());
  endtask

  int cyc     = 0;
  int last_ls = -1;
  int last_fs = -1;
  int en_cnt  = 0;
  bit prev_vs = 1'b0;
  bit prev_rst = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      $display("cyc %0d sx=%0d sy=%0d hs=%0b vs=%0b en=%0b ls=%0b fs=%0b fc=%04h",
               cyc, sx, sy, hsync, vsync, video_enable, line_start, frame_start, frame_count);
      chk("sx", int'(sx), e.sx, cyc);
      chk("sy", int'(sy), e.sy, cyc);
      chk("hsync", int'(hsync), int'(e.hs), cyc);
      chk("vsync", int'(vsync), int'(e.vs), cyc);
      chk("video_enable", int'(video_enable), int'(e.en), cyc);
      chk("line_start", int'(line_start), int'(e.ls), cyc);
      chk("frame_start", int'(frame_start), int'(e.fs), cyc);
      chk("frame_count", int'(frame_count), e.fc, cyc);
    end
    if (rst) begin
      last_ls = -1;
      last_fs = -1;
      en_cnt  = 0;
    end else begin
      if (video_enable) begin
        en_cnt++;
        chk("en_sx_range", int'(sx >= 0 && sx <= 7), 1, cyc);
        chk("en_sy_range", int'(sy >= 0 && sy <= 3), 1, cyc);
      end
      if (!prev_rst && (vsync !== prev_vs)) chk("vsync_edge_sx", int'(sx), -6, cyc);
      if (line_start) begin
        if (last_ls >= 0) chk("line_period", cyc - last_ls, 14, cyc);
        last_ls = cyc;
      end
      if (frame_start) begin
        chk("fs_at_origin", int'(sx == -6 && sy == -3), 1, cyc);
        if (last_fs >= 0) begin
          chk("frame_period", cyc - last_fs, 98, cyc);
          chk("en_per_frame", en_cnt, 32, cyc);
        end
        last_fs = cyc;
        en_cnt  = 0;
      end
    end
    prev_vs  = vsync;
    prev_rst = rst;
  end

  initial begin
    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (3 * 98 + 20) tick();
    mid_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (98 + 10) tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
